// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multicycle RISC-V core: opcodes, FSM
// state encoding and the datapath mux select encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXER, EXEI, ALUWB, BRANCH, JAL, FAULT
  } ctrlState_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode; anything unknown falls back to I.
  function automatic logic [1:0] immSrcOf(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   immSrcOf = IMM_S;
      OP_B:    immSrcOf = IMM_B;
      OP_JAL:  immSrcOf = IMM_J;
      default: immSrcOf = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready and flags the cycle
// that would be the MEM_TO-th wait, unless memory answers in that cycle.
module mem_wait_timer #(
  parameter int TO_W   = 4,
  parameter int MEM_TO = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic memReady,
  output logic timeout
);

  logic [TO_W-1:0] waitCount;

  // Count only while parked in a waiting state; any non-waiting cycle or a
  // ready response zeroes it, so every wait state is entered with a fresh count.
  always_ff @(posedge clk) begin
    if (rst)
      waitCount <= '0;
    else if (!waiting || memReady)
      waitCount <= '0;
    else
      waitCount <= waitCount + TO_W'(1);
  end

  // waitCount holds the number of earlier wait cycles, so MEM_TO-1 marks the last allowed one.
  assign timeout = waiting && !memReady && (waitCount == TO_W'(MEM_TO - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RISC-V core. Steps each instruction
// through fetch/decode/execute/memory/writeback with a memory-ready handshake
// and a sticky fault for illegal opcodes or memory timeouts.
// Optional build macro MC_CTRL_BNE_EN: adds bne (funct3=001) and faults on
// any other branch funct3; without it every branch is treated as beq.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W   = 7,
  parameter int TO_W   = 4,
  parameter int MEM_TO = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ImmSrc,
  output logic            fault
);

  ctrlState_t state, nextState;
  logic waiting, timeout, taken, badFunct3;

  assign waiting = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

  mem_wait_timer #(
    .TO_W  (TO_W),
    .MEM_TO(MEM_TO)
  ) uWaitTimer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .memReady(mem_ready),
    .timeout (timeout)
  );

`ifdef MC_CTRL_BNE_EN
  assign taken     = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  assign badFunct3 = (funct3 != 3'b000) && (funct3 != 3'b001);
`else
  logic unusedFunct3;
  assign unusedFunct3 = ^funct3;
  assign taken        = zero;
  assign badFunct3    = 1'b0;
`endif

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (rst)
      state <= FETCH;
    else
      state <= nextState;
  end

  // Next-state decode; FAULT only leaves through reset.
  always_comb begin
    nextState = state;
    case (state)
      FETCH:  nextState = timeout ? FAULT : (mem_ready ? DECODE : FETCH);
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXER;
          OP_I:         nextState = EXEI;
          OP_B:         nextState = BRANCH;
          OP_JAL:       nextState = JAL;
          default:      nextState = FAULT;
        endcase
      end
      MEMADR: nextState = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nextState = timeout ? FAULT : (mem_ready ? MEMWB : MEMRD);
      MEMWB:  nextState = FETCH;
      MEMWR:  nextState = timeout ? FAULT : (mem_ready ? FETCH : MEMWR);
      EXER:   nextState = ALUWB;
      EXEI:   nextState = ALUWB;
      ALUWB:  nextState = FETCH;
      BRANCH: nextState = badFunct3 ? FAULT : FETCH;
      JAL:    nextState = FETCH;
      FAULT:  nextState = FAULT;
      default: nextState = FAULT;
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALUOP_ADD;
    ImmSrc    = IMM_I;
    fault     = 1'b0;
    if (!rst) begin
      ImmSrc = immSrcOf(op[6:0]);
      case (state)
        FETCH: begin
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD: AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
        end
        MEMWR: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        EXER: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_FUNCT;
        end
        EXEI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        ALUWB: RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_SUB;
          PCWrite = taken;
        end
        JAL: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          PCWrite  = 1'b1;
          RegWrite = 1'b1;
        end
        FAULT: fault = 1'b1;
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm. Follows the
// MC_CTRL_BNE_EN macro so the branch checks match the build being tested.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  int compared = 0;
  int mismatched = 0;

  multicycle_control_fsm #(.OP_W(7), .TO_W(4), .MEM_TO(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .funct3   (funct3),
    .zero     (zero),
    .mem_ready(mem_ready),
    .PCWrite  (PCWrite),
    .AdrSrc   (AdrSrc),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .ResultSrc(ResultSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ImmSrc   (ImmSrc),
    .fault    (fault)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] observed;
  assign observed = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUOp, fault};

  function automatic logic [13:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] aop, input logic f);
    return {pcw, adr, mw, irw, rw, rs, a, b, aop, f};
  endfunction

  logic [13:0] allZero, fetchRdy, fetchWait, decodeS, memadrS, memrdS, memwbS, memwrS;
  logic [13:0] exerS, exeiS, aluwbS, branchT, branchN, jalS, faultS;

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic z, input logic rdy);
    op = o;
    funct3 = f3;
    zero = z;
    mem_ready = rdy;
  endtask

  // Compare the packed control word just after the falling edge, then move on one cycle.
  task automatic checkOutput(input string tag, input logic [13:0] expected);
    #1;
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
    @(negedge clk);
  endtask

  task automatic checkImm(input string tag, input logic [1:0] expected);
    #1;
    compared++;
    assert (ImmSrc === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, ImmSrc, expected);
    end
  endtask

  // Directed instruction walk-throughs with hand-derived control words per state.
  initial begin
    allZero   = '0;
    fetchRdy  = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    fetchWait = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    decodeS   = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
    memadrS   = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    memrdS    = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    memwbS    = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    memwrS    = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    exerS     = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    exeiS     = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
    aluwbS    = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    branchT   = mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
    branchN   = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
    jalS      = mk(1, 0, 0, 0, 1, 2'b00, 2'b01, 2'b10, 2'b00, 0);
    faultS    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);

    rst = 1'b1;
    applyStimulus(7'b0000011, 3'b000, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("reset outputs low", allZero);
    rst = 1'b0;

    // lw with memory always ready
    applyStimulus(7'b0000011, 3'b000, 1'b0, 1'b1);
    checkOutput("lw fetch", fetchRdy);
    checkImm("lw immsrc", 2'b00);
    checkOutput("lw decode", decodeS);
    checkOutput("lw memadr", memadrS);
    checkOutput("lw memrd", memrdS);
    checkOutput("lw memwb", memwbS);

    // sw held off three cycles in MEMWR
    applyStimulus(7'b0100011, 3'b000, 1'b0, 1'b1);
    checkOutput("sw fetch", fetchRdy);
    checkImm("sw immsrc", 2'b01);
    checkOutput("sw decode", decodeS);
    checkOutput("sw memadr", memadrS);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) checkOutput("sw memwr wait", memwrS);
    mem_ready = 1'b1;
    checkOutput("sw memwr done", memwrS);

    // R-type then I-type
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b1);
    checkOutput("r fetch", fetchRdy);
    checkOutput("r decode", decodeS);
    checkOutput("r exer", exerS);
    checkOutput("r aluwb", aluwbS);
    applyStimulus(7'b0010011, 3'b000, 1'b0, 1'b1);
    checkOutput("i fetch", fetchRdy);
    checkOutput("i decode", decodeS);
    checkOutput("i exei", exeiS);
    checkOutput("i aluwb", aluwbS);

    // beq taken and not taken
    applyStimulus(7'b1100011, 3'b000, 1'b1, 1'b1);
    checkOutput("beq fetch", fetchRdy);
    checkImm("beq immsrc", 2'b10);
    checkOutput("beq decode", decodeS);
    checkOutput("beq taken", branchT);
    zero = 1'b0;
    checkOutput("beq2 fetch", fetchRdy);
    checkOutput("beq2 decode", decodeS);
    checkOutput("beq not taken", branchN);

    // funct3=001: bne when enabled, beq-only behaviour otherwise
    applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1);
    checkOutput("f3=001 fetch", fetchRdy);
    checkOutput("f3=001 decode", decodeS);
`ifdef MC_CTRL_BNE_EN
    checkOutput("bne taken", branchT);
`else
    checkOutput("f3=001 zero=0 not taken", branchN);
`endif

    // jal writes PC and rd in the same cycle
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b1);
    checkOutput("jal fetch", fetchRdy);
    checkImm("jal immsrc", 2'b11);
    checkOutput("jal decode", decodeS);
    checkOutput("jal exec", jalS);

    // lw waits 11 cycles in MEMRD, answers on the 12th: no fault
    applyStimulus(7'b0000011, 3'b000, 1'b0, 1'b1);
    checkOutput("lw slow fetch", fetchRdy);
    checkOutput("lw slow decode", decodeS);
    checkOutput("lw slow memadr", memadrS);
    mem_ready = 1'b0;
    for (int i = 0; i < 11; i++) checkOutput("lw slow memrd wait", memrdS);
    mem_ready = 1'b1;
    checkOutput("lw slow memrd last", memrdS);
    checkOutput("lw slow memwb", memwbS);

    // reset in the middle of a store aborts it
    applyStimulus(7'b0100011, 3'b000, 1'b0, 1'b1);
    checkOutput("sw abort fetch", fetchRdy);
    checkOutput("sw abort decode", decodeS);
    checkOutput("sw abort memadr", memadrS);
    mem_ready = 1'b0;
    checkOutput("sw abort memwr", memwrS);
    rst = 1'b1;
    checkOutput("rst during memwr", allZero);
    rst = 1'b0;
    checkOutput("after abort fetch", fetchWait);

    // illegal opcode traps and stays trapped
    applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b1);
    checkOutput("illegal fetch", fetchRdy);
    checkOutput("illegal decode", decodeS);
    checkOutput("illegal fault", faultS);
    applyStimulus(7'b0100011, 3'b000, 1'b1, 1'b1);
    checkOutput("fault sticky sw", faultS);
    applyStimulus(7'b1101111, 3'b000, 1'b1, 1'b0);
    checkOutput("fault sticky jal", faultS);
    rst = 1'b1;
    checkOutput("fault reset", allZero);
    rst = 1'b0;

    // fetch starved for MEM_TO cycles times out
    applyStimulus(7'b0000011, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) checkOutput("fetch starve", fetchWait);
    checkOutput("timeout fault", faultS);
    mem_ready = 1'b1;
    checkOutput("timeout fault sticky", faultS);
    rst = 1'b1;
    checkOutput("timeout reset", allZero);
    rst = 1'b0;
    checkOutput("fetch after recovery", fetchRdy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
